// File: rtl/keypad_emulator_if.sv
// Request/sense bundle between a keypad scanner (or test driver) and the keypad emulator.
// The master side drives rows and press requests; the slave side returns columns and status.
interface keypad_emulator_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       req_valid;
  logic [3:0] req_key;
  logic [7:0] req_hold;
  logic       abort;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic       contact;

  modport master (
    output row, req_valid, req_key, req_hold, abort,
    input  col, req_ready, busy, done, contact
  );

  modport slave (
    input  row, req_valid, req_key, req_hold, abort,
    output col, req_ready, busy, done, contact
  );
endinterface

// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad model: plays one requested press at a time as press bounce, hold,
// release bounce and an idle gap on a millisecond tick, answering the scanner's row drive.
module keypad_emulator #(
  parameter int TICK_COUNT   = 48000,
  parameter int BOUNCE_TICKS = 8,
  parameter int GAP_TICKS    = 20
) (
  input  logic             clk,
  input  logic             reset,
  keypad_emulator_if.slave kp
);

  localparam int TW   = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam int MAXT = (BOUNCE_TICKS > GAP_TICKS) ? BOUNCE_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;

  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_COUNT - 1);
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_P,
    HOLD,
    BOUNCE_R,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tickCnt_q, tickCnt_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [CW-1:0] gcnt_q, gcnt_d;
  logic [7:0]    hcnt_q, hcnt_d;
  logic [3:0]    key_q, key_d;
  logic [7:0]    hold_q, hold_d;

  logic       tick;
  logic       reqReady;
  logic       accept;
  logic       contactRaw;
  logic       doneRaw;
  logic       contactOut;
  logic [3:0] colVec;

  // Free-running timebase; requests never realign it.
  always_comb begin
    tick      = (tickCnt_q == TICK_LAST);
    tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tickCnt_q <= '0;
      state_q   <= IDLE;
      bcnt_q    <= '0;
      gcnt_q    <= '0;
      hcnt_q    <= '0;
      key_q     <= '0;
      hold_q    <= '0;
    end else begin
      tickCnt_q <= tickCnt_d;
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      gcnt_q    <= gcnt_d;
      hcnt_q    <= hcnt_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
    end
  end

  // Ready is gated by the reset input so it stays low for the whole reset assertion.
  assign reqReady = (state_q == IDLE) && reset;
  assign accept   = kp.req_valid && reqReady;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    gcnt_d     = gcnt_q;
    hcnt_d     = hcnt_q;
    key_d      = key_q;
    hold_d     = hold_q;
    contactRaw = 1'b0;
    doneRaw    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BOUNCE_P;
          bcnt_d  = '0;
          key_d   = kp.req_key;
          hold_d  = (kp.req_hold == 8'd0) ? 8'd1 : kp.req_hold;
        end
      end

      BOUNCE_P: begin
        contactRaw = ~bcnt_q[0];
        if (tick) begin
          if (bcnt_q == BOUNCE_LAST) begin
            state_d = HOLD;
            hcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end

      // Abort wins over a coincident expiry tick; both lead to the same release path.
      HOLD: begin
        contactRaw = 1'b1;
        if (kp.abort) begin
          state_d = BOUNCE_R;
          bcnt_d  = '0;
        end else if (tick) begin
          if (hcnt_q == hold_q - 8'd1) begin
            state_d = BOUNCE_R;
            bcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + 8'd1;
          end
        end
      end

      BOUNCE_R: begin
        contactRaw = bcnt_q[0];
        if (tick) begin
          if (bcnt_q == BOUNCE_LAST) begin
            state_d = GAP;
            gcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + CW'(1);
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (gcnt_q == GAP_LAST) begin
            state_d = IDLE;
            doneRaw = 1'b1;
          end else begin
            gcnt_d = gcnt_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Reset gating lets col fall in the very cycle reset is applied, before the state clears.
  assign contactOut = contactRaw && reset;

  always_comb begin
    colVec = '0;
    if (contactOut && kp.row[key_q[3:2]]) begin
      colVec[key_q[1:0]] = 1'b1;
    end
  end

  assign kp.col       = colVec;
  assign kp.contact   = contactOut;
  assign kp.req_ready = reqReady;
  assign kp.busy      = (state_q != IDLE) && reset;
  assign kp.done      = doneRaw && reset;

endmodule
